// File: rtl/nano2_memsys.sv
// Small memory system for a soft core: registered-output RAM, a reload timer
// with interrupt, and a GPIO block on a simple read/write bus with waitrequest.
module nano2_memsys #(
   parameter int WIDTHA   = 12,
   parameter int WIDTHD   = 32,
   parameter int RAMWORDS = 1024
) (
   input  logic              clock,
   input  logic              sreset_n,
   input  logic [WIDTHA-1:0] address,
   input  logic [WIDTHD-1:0] writedata,
   output logic [WIDTHD-1:0] readdata,
   input  logic              read,
   input  logic              write,
   output logic              waitrequest,
   output logic              irq,
   input  logic [7:0]        gpio_in,
   output logic [7:0]        gpio_out
);

   localparam int RAW = $clog2(RAMWORDS);
   localparam logic [WIDTHA-1:0] IO_BASE = WIDTHA'('h400);

   typedef enum logic {IDLE, RDWAIT} state_t;

   state_t state, state_next;

   logic [WIDTHD-1:0] ram [RAMWORDS];
   logic [WIDTHD-1:0] rd_mux;
   logic [WIDTHD-1:0] reload;
   logic [WIDTHD-1:0] count;
   logic              en;
   logic              ie;
   logic              pend;
   logic [7:0]        sync1;
   logic [7:0]        sync2;

   logic              ram_sel;
   logic              io_sel;
   logic [RAW-1:0]    ram_addr;
   logic [3:0]        io_reg;
   logic              rd_start;
   logic              io_wr;
   logic              expire;

   assign ram_sel  = int'(address) < RAMWORDS;
   assign io_sel   = address[WIDTHA-1:4] == IO_BASE[WIDTHA-1:4];
   assign ram_addr = address[RAW-1:0];
   assign io_reg   = address[3:0];
   assign io_wr    = write && io_sel;
   assign expire   = en && (count == '0);

   // A simultaneous write wins over a read, so only a pure read stalls.
   assign rd_start    = read && !write && (state == IDLE);
   assign waitrequest = rd_start;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rd_start) state_next = RDWAIT;
         RDWAIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      if (ram_sel) begin
         rd_mux = ram[ram_addr];
      end else if (io_sel) begin
         case (io_reg)
            4'h0:    rd_mux = reload;
            4'h1:    rd_mux = count;
            4'h2:    rd_mux = WIDTHD'({ie, en});
            4'h3:    rd_mux = WIDTHD'(pend);
            4'h4:    rd_mux = WIDTHD'(gpio_out);
            4'h5:    rd_mux = WIDTHD'(sync2);
            default: rd_mux = '0;
         endcase
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clock) begin
      if (write && ram_sel) ram[ram_addr] <= writedata;
   end

   always_ff @(posedge clock) begin
      if (!sreset_n) begin
         state    <= IDLE;
         readdata <= '0;
         irq      <= 1'b0;
         gpio_out <= '0;
         reload   <= '0;
         count    <= '0;
         en       <= 1'b0;
         ie       <= 1'b0;
         pend     <= 1'b0;
         sync1    <= '0;
         sync2    <= '0;
      end else begin
         state <= state_next;
         if (rd_start) readdata <= rd_mux;

         sync1 <= gpio_in;
         sync2 <= sync1;
         irq   <= pend && ie;

         if (io_wr && io_reg == 4'h0) reload <= writedata;
         if (io_wr && io_reg == 4'h4) gpio_out <= writedata[7:0];
         if (io_wr && io_reg == 4'h2) begin
            en <= writedata[0];
            ie <= writedata[1];
         end

         // Enabling from idle restarts the count; otherwise RELOAD only matters at expiry.
         if (io_wr && io_reg == 4'h2 && !en && writedata[0]) count <= reload;
         else if (expire) count <= reload;
         else if (en) count <= count - 1'b1;

         if (expire) pend <= 1'b1;
         else if (io_wr && io_reg == 4'h3 && writedata[0]) pend <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nano2_memsys.sv
// Self-checking bench for nano2_memsys: bus reads are scored against a queue of
// expected data pushed when each read is issued.
module tb_nano2_memsys;

   logic        clock = 1'b0;
   logic        sreset_n;
   logic [11:0] address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic        irq;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;

   int          errorCount = 0;
   int          checkCount = 0;
   logic [31:0] expQ[$];
   logic [31:0] ramData[8];

   nano2_memsys #(.WIDTHA(12), .WIDTHD(32), .RAMWORDS(1024)) dut (
      .clock       (clock),
      .sreset_n    (sreset_n),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .read        (read),
      .write       (write),
      .waitrequest (waitrequest),
      .irq         (irq),
      .gpio_in     (gpio_in),
      .gpio_out    (gpio_out)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // One bus cycle: inputs change on the falling edge, outputs are sampled 1ns later.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [11:0] addr, input logic [31:0] data);
      @(negedge clock);
      read      = rd;
      write     = wr;
      address   = addr;
      writedata = data;
      #1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 12'h000, 32'h0);
   endtask

   task automatic busWrite(input logic [11:0] addr, input logic [31:0] data);
      applyStimulus(1'b0, 1'b1, addr, data);
   endtask

   task automatic busRead(input logic [11:0] addr, input logic [31:0] expected, input string tag);
      int waits;
      logic [31:0] want;
      expQ.push_back(expected);
      applyStimulus(1'b1, 1'b0, addr, 32'h0);
      waits = 0;
      while (waitrequest && waits < 8) begin
         waits++;
         applyStimulus(1'b1, 1'b0, addr, 32'h0);
      end
      checkOutput({tag, " waits"}, waits, 1);
      want = expQ.pop_front();
      checkOutput(tag, readdata, want);
   endtask

   initial begin
      sreset_n  = 1'b0;
      read      = 1'b0;
      write     = 1'b0;
      address   = '0;
      writedata = '0;
      gpio_in   = '0;
      repeat (3) @(negedge clock);
      #1;
      checkOutput("reset irq", irq, 0);
      checkOutput("reset gpio_out", gpio_out, 0);
      checkOutput("reset readdata", readdata, 0);
      checkOutput("reset waitrequest", waitrequest, 0);
      @(negedge clock);
      sreset_n = 1'b1;

      busRead(12'h401, 0, "count rst");
      busRead(12'h402, 0, "ctrl rst");
      busRead(12'h403, 0, "status rst");
      busRead(12'h405, 0, "gpi rst");

      busWrite(12'h3E0, 32'hDEADBEEF);
      busRead(12'h3E0, 32'hDEADBEEF, "ram 3e0");
      busWrite(12'h004, 32'h11);
      busWrite(12'h005, 32'h22);
      busRead(12'h004, 32'h11, "b2b 004");
      busRead(12'h005, 32'h22, "b2b 005");

      for (int i = 0; i < 8; i++) begin
         ramData[i] = $urandom;
         busWrite(12'h100 + 12'(i * 37), ramData[i]);
      end
      for (int i = 0; i < 8; i++) busRead(12'h100 + 12'(i * 37), ramData[i], "ram rand");

      busWrite(12'h3FF, 32'hCAFE0001);
      busWrite(12'h000, 32'h55);
      busWrite(12'h800, 32'hFFFFFFFF);
      busRead(12'h3FF, 32'hCAFE0001, "ram top");
      busRead(12'h000, 32'h55, "unmapped wr ram");
      busRead(12'h400, 0, "unmapped wr reload");
      busRead(12'h800, 0, "unmapped rd");
      busRead(12'h40A, 0, "io hole");

      applyStimulus(1'b1, 1'b1, 12'h010, 32'h77);
      checkOutput("rdwr waitrequest", waitrequest, 0);
      busRead(12'h010, 32'h77, "rdwr data");

      busWrite(12'h404, 32'hFFFFFF3C);
      idleCycles(1);
      checkOutput("gpio_out", gpio_out, 8'h3C);
      busRead(12'h404, 32'h3C, "gpo rd");
      gpio_in = 8'hA5;
      busRead(12'h405, 0, "gpi early");
      busRead(12'h405, 32'hA5, "gpi sync");

      busWrite(12'h400, 3);
      for (int d = 1; d <= 4; d++) begin
         busWrite(12'h402, 0);
         busWrite(12'h402, 1);
         idleCycles(d - 1);
         busRead(12'h401, 32'(4 - d), "count seq");
      end
      checkOutput("irq masked", irq, 0);

      busWrite(12'h402, 0);
      busWrite(12'h403, 1);
      busWrite(12'h402, 1);
      busRead(12'h403, 0, "pend early");
      idleCycles(2);
      busRead(12'h403, 1, "pend set");

      busWrite(12'h402, 0);
      busWrite(12'h403, 1);
      busWrite(12'h402, 3);
      idleCycles(5);
      checkOutput("irq before", irq, 0);
      busWrite(12'h403, 1);
      checkOutput("irq set", irq, 1);
      idleCycles(1);
      checkOutput("irq hold", irq, 1);
      idleCycles(1);
      checkOutput("irq clear", irq, 0);
      idleCycles(1);
      busWrite(12'h403, 1);
      idleCycles(1);
      busWrite(12'h403, 1);
      checkOutput("irq after clr", irq, 0);
      busRead(12'h403, 1, "pend priority");
      checkOutput("irq again", irq, 1);

      busWrite(12'h402, 0);
      busWrite(12'h403, 1);
      busWrite(12'h402, 1);
      busWrite(12'h400, 7);
      busRead(12'h401, 2, "count old reload");
      idleCycles(1);
      busRead(12'h401, 7, "count new reload");

      busWrite(12'h402, 0);
      busWrite(12'h400, 0);
      busWrite(12'h403, 1);
      busWrite(12'h402, 1);
      idleCycles(1);
      busWrite(12'h403, 1);
      busRead(12'h403, 1, "reload0 pend");
      busRead(12'h401, 0, "reload0 count");

      busWrite(12'h402, 3);
      idleCycles(2);
      checkOutput("irq pre-rst", irq, 1);
      applyStimulus(1'b1, 1'b0, 12'h3E0, 32'h0);
      checkOutput("rst rd wait", waitrequest, 1);
      @(negedge clock);
      sreset_n = 1'b0;
      @(negedge clock);
      sreset_n = 1'b1;
      read     = 1'b0;
      #1;
      checkOutput("post-rst irq", irq, 0);
      checkOutput("post-rst gpio_out", gpio_out, 0);
      checkOutput("post-rst readdata", readdata, 0);
      checkOutput("post-rst waitrequest", waitrequest, 0);
      busRead(12'h3E0, 32'hDEADBEEF, "ram kept");
      busRead(12'h402, 0, "ctrl post-rst");
      busRead(12'h400, 0, "reload post-rst");

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
